prog_run_ctrl: RTL and testbench

Run controller for the 3BC processor. It accepts a host request to run one of several programs stored in instruction ROM, loads the program counter with that program's base address, and drives the core's Start pulse. It then monitors the core's Ack done flag, counts execution cycles, and applies a timeout. It sits between the testbench/host and the processor top level, replacing direct host drive of Start.

---
 rtl/prog_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_prog_run_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/prog_run_ctrl.sv
// Run controller for the 3BC core: loads the selected program's base PC, holds Start,
// then times the run until the core reports done, the timeout expires, or the host aborts.
module prog_run_ctrl #(
  parameter int unsigned      PC_W        = 10,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [PC_W-1:0]  PROG0_BASE  = 10'd0,
  parameter logic [PC_W-1:0]  PROG1_BASE  = 10'd256,
  parameter logic [PC_W-1:0]  PROG2_BASE  = 10'd512,
  parameter int unsigned      START_LEN   = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic [1:0]       ProgSel,
  input  logic             Abort,
  input  logic             CoreAck,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadAddr,
  output logic             CoreStart,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic             Reject,
  output logic [1:0]       RunIdx,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int unsigned SL_W        = 4;
  localparam logic [1:0]  SEL_INVALID = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SL_W-1:0]  start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             rej_lock_q, rej_lock_d;
  logic             pc_load_q, pc_load_d;
  logic [PC_W-1:0]  pc_load_addr_q, pc_load_addr_d;
  logic             core_start_q, core_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic             reject_q, reject_d;
  logic [1:0]       run_idx_q, run_idx_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
    case (sel)
      2'd1:    base_of = PROG1_BASE;
      2'd2:    base_of = PROG2_BASE;
      default: base_of = PROG0_BASE;
    endcase
  endfunction

  // Next-state and next-output logic; CoreAck only matters in RUN.
  always_comb begin
    state_d        = state_q;
    start_cnt_d    = start_cnt_q;
    run_cnt_d      = run_cnt_q;
    rej_lock_d     = 1'b0;
    pc_load_addr_d = pc_load_addr_q;
    timed_out_d    = timed_out_q;
    reject_d       = 1'b0;
    run_idx_d      = run_idx_q;
    cycle_count_d  = cycle_count_q;

    case (state_q)
      S_IDLE: begin
        if (Go) begin
          if (ProgSel == SEL_INVALID) begin
            // One Reject per invalid request, however long Go is held.
            reject_d   = ~rej_lock_q;
            rej_lock_d = 1'b1;
          end else begin
            state_d        = S_LOAD;
            run_idx_d      = ProgSel;
            pc_load_addr_d = base_of(ProgSel);
          end
        end
      end
      S_LOAD: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_START;
          start_cnt_d = SL_W'(1);
        end
      end
      S_START: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (start_cnt_q >= SL_W'(START_LEN)) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + SL_W'(1);
        end
      end
      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (CoreAck) begin
          state_d       = S_DONE;
          cycle_count_d = run_cnt_q;
          timed_out_d   = 1'b0;
        end else if (run_cnt_q == TIMEOUT_CYC) begin
          state_d       = S_DONE;
          cycle_count_d = TIMEOUT_CYC;
          timed_out_d   = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!Go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pc_load_d    = (state_d == S_LOAD);
    core_start_d = (state_d == S_START);
    busy_d       = (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      start_cnt_q    <= '0;
      run_cnt_q      <= '0;
      rej_lock_q     <= 1'b0;
      pc_load_q      <= 1'b0;
      pc_load_addr_q <= '0;
      core_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      reject_q       <= 1'b0;
      run_idx_q      <= '0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      start_cnt_q    <= start_cnt_d;
      run_cnt_q      <= run_cnt_d;
      rej_lock_q     <= rej_lock_d;
      pc_load_q      <= pc_load_d;
      pc_load_addr_q <= pc_load_addr_d;
      core_start_q   <= core_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timed_out_q    <= timed_out_d;
      reject_q       <= reject_d;
      run_idx_q      <= run_idx_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign PcLoad     = pc_load_q;
  assign PcLoadAddr = pc_load_addr_q;
  assign CoreStart  = core_start_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign TimedOut   = timed_out_q;
  assign Reject     = reject_q;
  assign RunIdx     = run_idx_q;
  assign CycleCount = cycle_count_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: directed vector table, corner-case sequences, and random
// stimulus checked against a timeline-based reference model.
module tb_prog_run_ctrl;

  localparam int SL = 2;
  localparam int TO = 20;

  logic        Clk = 1'b0;
  logic        Reset, Go, Abort, CoreAck;
  logic [1:0]  ProgSel;
  logic        PcLoad, CoreStart, Busy, Done, TimedOut, Reject;
  logic [9:0]  PcLoadAddr;
  logic [1:0]  RunIdx;
  logic [15:0] CycleCount;

  prog_run_ctrl #(
    .PC_W(10), .CNT_W(16),
    .PROG0_BASE(10'd0), .PROG1_BASE(10'd256), .PROG2_BASE(10'd512),
    .START_LEN(SL), .TIMEOUT_CYC(16'(TO))
  ) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .ProgSel(ProgSel), .Abort(Abort), .CoreAck(CoreAck),
    .PcLoad(PcLoad), .PcLoadAddr(PcLoadAddr), .CoreStart(CoreStart), .Busy(Busy), .Done(Done),
    .TimedOut(TimedOut), .Reject(Reject), .RunIdx(RunIdx), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  logic [33:0] dut_out;
  assign dut_out = {PcLoad, PcLoadAddr, CoreStart, Busy, Done, TimedOut, Reject, RunIdx, CycleCount};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a run is tracked by its age in cycles since the accepting edge.
  bit          m_act, m_done, m_prev_inv, m_rej, m_to;
  int          m_age;
  logic [1:0]  m_idx;
  logic [9:0]  m_addr;
  logic [15:0] m_cc;

  task automatic model_step(input logic r, g, input logic [1:0] s, input logic ab, ak);
    int k;
    m_rej = 1'b0;
    if (r) begin
      m_act = 0; m_done = 0; m_prev_inv = 0; m_to = 0; m_age = 0;
      m_idx = '0; m_addr = '0; m_cc = '0;
    end else if (m_act) begin
      m_prev_inv = 0;
      if (ab) m_act = 0;
      else if (m_age >= SL + 2) begin
        k = m_age - SL - 1;
        if (ak) begin
          m_cc = 16'(k - 1); m_to = 0; m_act = 0; m_done = 1;
        end else if (k - 1 == TO) begin
          m_cc = 16'(TO); m_to = 1; m_act = 0; m_done = 1;
        end else m_age++;
      end else m_age++;
    end else if (m_done) begin
      m_prev_inv = 0;
      if (!g) m_done = 0;
    end else begin
      if (g && s != 2'd3) begin
        m_act = 1; m_age = 1; m_idx = s; m_addr = 10'(256 * int'(s)); m_prev_inv = 0;
      end else if (g) begin
        m_rej = !m_prev_inv; m_prev_inv = 1;
      end else m_prev_inv = 0;
    end
  endtask

  function automatic logic [33:0] exp_out();
    logic pcl, cs;
    pcl = m_act && (m_age == 1);
    cs  = m_act && (m_age >= 2) && (m_age <= SL + 1);
    return {pcl, m_addr, cs, m_act, m_done, m_to, m_rej, m_idx, m_cc};
  endfunction

  task automatic chk(input string nm, input logic [33:0] got, input logic [33:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input logic r, g, input logic [1:0] s, input logic ab, ak);
    Reset = r; Go = g; ProgSel = s; Abort = ab; CoreAck = ak;
    @(posedge Clk);
    model_step(r, g, s, ab, ak);
    #1;
    chk("model", dut_out, exp_out());
  endtask

  typedef struct {
    logic rst; logic go; logic [1:0] sel; logic ab; logic ak;
    logic [33:0] exp;
  } vec_t;

  function automatic vec_t mkv(input int rst, go, sel, ab, ak,
                               input int pcl, addr, cs, bsy, dn, to, rj, idx, cc);
    vec_t v;
    v.rst = 1'(rst); v.go = 1'(go); v.sel = 2'(sel); v.ab = 1'(ab); v.ak = 1'(ak);
    v.exp = {1'(pcl), 10'(addr), 1'(cs), 1'(bsy), 1'(dn), 1'(to), 1'(rj), 2'(idx), 16'(cc)};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic g;
    int   ack_mode;
    logic ak;

    //              rst go sel ab ak | pcl addr cs bsy dn to rj idx cc
    tbl.push_back(mkv(1, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 0,   1, 256, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 0,   0, 256, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 0,   0, 256, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 256, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 1,   0, 256, 0, 0, 1, 0, 0, 1, 4));
    tbl.push_back(mkv(0, 1, 1, 0, 0,   0, 256, 0, 0, 1, 0, 0, 1, 4));
    tbl.push_back(mkv(0, 0, 1, 0, 0,   0, 256, 0, 0, 0, 0, 0, 1, 4));
    // Stale Ack held through LOAD/START is ignored
    tbl.push_back(mkv(0, 1, 0, 0, 1,   1,   0, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mkv(0, 0, 0, 0, 1,   0,   0, 1, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mkv(0, 0, 0, 0, 1,   0,   0, 1, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mkv(0, 0, 0, 0, 1,   0,   0, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mkv(0, 0, 0, 0, 0,   0,   0, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mkv(0, 0, 0, 0, 1,   0,   0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 1));
    // Invalid program held four cycles: single Reject
    tbl.push_back(mkv(0, 1, 3, 0, 0,   0,   0, 0, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 3, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].go, tbl[i].sel, tbl[i].ab, tbl[i].ak);
      chk($sformatf("tbl[%0d]", i), dut_out, tbl[i].exp);
    end

    // Timeout: no Ack, run ends after the 21st RUN cycle
    cycle(0, 1, 2, 0, 0);
    repeat (23) cycle(0, 0, 0, 0, 0);
    chk("to_busy", 34'({Busy, Done}), 34'(2'b10));
    cycle(0, 0, 0, 0, 0);
    chk("to_flags", 34'({Busy, Done, TimedOut}), 34'(3'b011));
    chk("to_cc", 34'(CycleCount), 34'(TO));
    chk("to_idx", 34'(RunIdx), 34'(2));
    cycle(0, 0, 0, 0, 0);
    chk("to_exit", 34'({Busy, Done}), 34'(2'b00));

    // Abort beats Ack in the 3rd RUN cycle
    cycle(0, 1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    chk("ab_run", 34'({Busy, CoreStart}), 34'(2'b10));
    cycle(0, 0, 0, 1, 1);
    chk("ab_flags", 34'({Busy, Done, CoreStart, PcLoad}), 34'(4'b0000));
    chk("ab_cc", 34'(CycleCount), 34'(TO));
    cycle(0, 0, 0, 0, 1);
    chk("ab_idle", 34'({Busy, Done}), 34'(2'b00));

    // Reset during START
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("rs_start", 34'(CoreStart), 34'(1));
    cycle(1, 0, 0, 0, 0);
    chk("rs_all0", dut_out, 34'(0));

    // Random traffic
    g = 1'b0;
    ack_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ack_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) g = ~g;
      case (ack_mode)
        0:       ak = 1'b0;
        1:       ak = ($urandom_range(0, 3) == 0);
        default: ak = ($urandom_range(0, 29) == 0);
      endcase
      cycle(($urandom_range(0, 299) == 0), g, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 59) == 0), ak);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
